// File: rtl/fifo_pkg.sv
// Shared types and pointer helpers for both sides of the dual-clock FIFO.
package fifo_pkg;

    localparam int DEF_PTR_WIDTH  = 3;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_FIFO_WIDTH = 16;

    typedef logic [DEF_PTR_WIDTH:0] ptr_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[DEF_PTR_WIDTH] = g[DEF_PTR_WIDTH];
        for (int i = DEF_PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Valid/ready output stream from the FIFO read controller to its consumer.
interface fifo_rd_ctrl_if #(
    parameter int FIFO_WIDTH = fifo_pkg::DEF_FIFO_WIDTH
);
    logic                  m_valid;
    logic                  m_ready;
    logic [FIFO_WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_ctrl_chk.sv
// Invariant checks for the read controller's output buffer and pointers.
module fifo_rd_ctrl_chk
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH  = DEF_PTR_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input logic               clk,
    input logic               rst,
    input buf_state_e         state,
    input logic               push,
    input logic               pop,
    input logic               fifo_empty,
    input logic               rd_en,
    input logic [PTR_WIDTH:0] rd_level
);
    localparam logic [PTR_WIDTH:0] DEPTH_P = FIFO_DEPTH[PTR_WIDTH:0];

    a_no_overfill: assert property (@(posedge clk) disable iff (rst) !(state == TWO && push && !pop));
    a_no_underrun: assert property (@(posedge clk) disable iff (rst) !(fifo_empty && rd_en));
    a_level_range: assert property (@(posedge clk) disable iff (rst) rd_level <= DEPTH_P);
endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for Gray-coded pointers crossing clock domains.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q1_r;
    logic [WIDTH-1:0] q2_r;

    // Plain flop chain, nothing between stages
    always_ff @(posedge clk) begin
        if (rst) begin
            q1_r <= {WIDTH{1'b0}};
            q2_r <= {WIDTH{1'b0}};
        end else begin
            q1_r <= d;
            q2_r <= q1_r;
        end
    end

    assign q = q2_r;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO (rdclk domain only).
// Optional registered read-side level output is enabled by defining FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int PTR_WIDTH  = DEF_PTR_WIDTH
) (
    input  logic                  rdclk,
    input  logic                  rd_rst,
    input  logic [PTR_WIDTH:0]    g_wptr,
    output logic                  rd_en,
    output logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] mem_rdata,
    output logic [PTR_WIDTH:0]    rd_level,
    fifo_rd_ctrl_if.master        m_if
);
    logic [PTR_WIDTH:0]    wq2_s;
    logic [PTR_WIDTH:0]    b_rptr_r;
    logic [PTR_WIDTH:0]    g_rptr_r;
    logic [PTR_WIDTH:0]    b_rptr_nxt_s;
    logic                  inflight_r;
    buf_state_e            state_r;
    logic                  m_valid_r;
    logic [FIFO_WIDTH-1:0] buf0_r;
    logic [FIFO_WIDTH-1:0] buf1_r;
    logic [1:0]            cnt_s;
    logic [2:0]            fill_s;
    logic                  pop_s;
    logic                  rd_en_s;

    sync_2ff #(.WIDTH(PTR_WIDTH + 1)) u_wptr_sync (
        .clk (rdclk),
        .rst (rd_rst),
        .d   (g_wptr),
        .q   (wq2_s)
    );

    // Read issue: only when a word is visible and the buffer will have room when it lands
    always_comb begin
        cnt_s = 2'd0;
        case (state_r)
            EMPTY:   cnt_s = 2'd0;
            ONE:     cnt_s = 2'd1;
            TWO:     cnt_s = 2'd2;
            default: cnt_s = 2'd0;
        endcase
        pop_s        = m_valid_r & m_if.m_ready;
        fill_s       = {1'b0, cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        rd_en_s      = (g_rptr_r != wq2_s) && (fill_s < 3'd2);
        b_rptr_nxt_s = b_rptr_r + {{PTR_WIDTH{1'b0}}, 1'b1};
    end

    // Read pointers and the one-cycle memory latency tracker
    always_ff @(posedge rdclk) begin
        if (rd_rst) begin
            b_rptr_r   <= {(PTR_WIDTH + 1){1'b0}};
            g_rptr_r   <= {(PTR_WIDTH + 1){1'b0}};
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_en_s;
            if (rd_en_s) begin
                b_rptr_r <= b_rptr_nxt_s;
                g_rptr_r <= bin2gray(b_rptr_nxt_s);
            end
        end
    end

    // Output buffer FSM; buf0_r is always the head so m_data holds while stalled
    always_ff @(posedge rdclk) begin
        if (rd_rst) begin
            state_r   <= EMPTY;
            m_valid_r <= 1'b0;
            buf0_r    <= {FIFO_WIDTH{1'b0}};
            buf1_r    <= {FIFO_WIDTH{1'b0}};
        end else begin
            case (state_r)
                EMPTY: begin
                    if (inflight_r) begin
                        buf0_r    <= mem_rdata;
                        state_r   <= ONE;
                        m_valid_r <= 1'b1;
                    end
                end
                ONE: begin
                    if (inflight_r && !pop_s) begin
                        buf1_r  <= mem_rdata;
                        state_r <= TWO;
                    end else if (inflight_r && pop_s) begin
                        buf0_r <= mem_rdata;
                    end else if (pop_s) begin
                        state_r   <= EMPTY;
                        m_valid_r <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop_s) begin
                        buf0_r <= buf1_r;
                        if (inflight_r) begin
                            buf1_r <= mem_rdata;
                        end else begin
                            state_r <= ONE;
                        end
                    end
                end
                default: begin
                    state_r   <= EMPTY;
                    m_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [PTR_WIDTH:0] rd_level_r;

    // Occupancy as seen here; lags the writer by the synchroniser delay
    always_ff @(posedge rdclk) begin
        if (rd_rst) begin
            rd_level_r <= {(PTR_WIDTH + 1){1'b0}};
        end else begin
            rd_level_r <= gray2bin(wq2_s) - b_rptr_r;
        end
    end

    assign rd_level = rd_level_r;
`else
    assign rd_level = {(PTR_WIDTH + 1){1'b0}};
`endif

    assign rd_en        = rd_en_s;
    assign b_rptr       = b_rptr_r;
    assign g_rptr       = g_rptr_r;
    assign fifo_empty   = (g_rptr_r == wq2_s);
    assign m_if.m_valid = m_valid_r;
    assign m_if.m_data  = buf0_r;

    fifo_rd_ctrl_chk #(
        .PTR_WIDTH  (PTR_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk        (rdclk),
        .rst        (rd_rst),
        .state      (state_r),
        .push       (inflight_r),
        .pop        (pop_s),
        .fifo_empty (fifo_empty),
        .rd_en      (rd_en_s),
        .rd_level   (rd_level)
    );
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: memory + writer model, in-order scoreboard, vector table, corner sequences.
module tb_fifo_rd_ctrl;
    localparam int PW = 3;
    localparam int W  = 16;

    logic          rdclk     = 1'b0;
    logic          rd_rst    = 1'b1;
    logic [PW:0]   g_wptr    = 4'd0;
    logic [W-1:0]  mem_rdata = 16'h0000;
    logic          rd_en;
    logic          fifo_empty;
    logic [PW:0]   b_rptr;
    logic [PW:0]   g_rptr;
    logic [PW:0]   rd_level;

    fifo_rd_ctrl_if #(.FIFO_WIDTH(W)) s_if ();

    fifo_rd_ctrl #(.FIFO_DEPTH(8), .FIFO_WIDTH(W), .PTR_WIDTH(PW)) dut (
        .rdclk      (rdclk),
        .rd_rst     (rd_rst),
        .g_wptr     (g_wptr),
        .rd_en      (rd_en),
        .b_rptr     (b_rptr),
        .g_rptr     (g_rptr),
        .fifo_empty (fifo_empty),
        .mem_rdata  (mem_rdata),
        .rd_level   (rd_level),
        .m_if       (s_if)
    );

    always #5 rdclk = ~rdclk;

    logic [W-1:0] mem [8];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] data_prev;
    int  wptr = 0;
    int  rd_cnt = 0;
    int  total = 0;
    int  bad = 0;
    bit  mon_en = 1'b0;
    bit  stall_prev = 1'b0;

    typedef struct {
        int          n;
        logic        v;
        logic        e;
        logic [PW:0] r;
        logic [W-1:0] d;
        logic [PW:0] l;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [PW:0] gray(input int n);
        logic [PW:0] b;
        b = n[PW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge rdclk);
        #1;
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        g_wptr = 4'd0;
        wptr = 0;
        s_if.m_ready = 1'b0;
        repeat (2) tick();
        rd_rst = 1'b0;
    endtask

    task automatic write_word(input logic [W-1:0] d);
        mem[wptr[PW-1:0]] = d;
        exp_q.push_back(d);
        wptr++;
        g_wptr = gray(wptr);
    endtask

    // FIFO memory: registered read, one cycle after rd_en
    always @(posedge rdclk) if (rd_en) mem_rdata <= mem[b_rptr[PW-1:0]];

    always @(posedge rdclk) begin
        if (rd_rst) rd_cnt <= 0;
        else if (rd_en) rd_cnt <= rd_cnt + 1;
    end

    // Scoreboard: pointers track read count, no underrun, order, hold under stall
    always @(negedge rdclk) begin
        if (mon_en) begin
            if (rd_rst) begin
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                check("b_rptr", 32'(b_rptr), 32'(rd_cnt[PW:0]));
                check("g_rptr", 32'(g_rptr), 32'(gray(rd_cnt)));
                if (rd_en) check("underflow", 32'(wptr - rd_cnt > 0), 32'd1);
                if (stall_prev) check("hold", 32'(s_if.m_data), 32'(data_prev));
                if (s_if.m_valid && s_if.m_ready) begin
                    if (exp_q.size() == 0) check("extra_word", 32'd1, 32'd0);
                    else check("order", 32'(s_if.m_data), 32'(exp_q.pop_front()));
                end
                stall_prev = s_if.m_valid && !s_if.m_ready;
                data_prev  = s_if.m_data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cnt;
        bit seen;
        logic [PW:0] exp_l;
        s_if.m_ready = 1'b0;

        tbl[0] = '{n: 0, v: 1'b0, e: 1'b1, r: 4'd0, d: 16'h0000, l: 4'd0};
        tbl[1] = '{n: 1, v: 1'b1, e: 1'b1, r: 4'd1, d: 16'h1000, l: 4'd0};
        tbl[2] = '{n: 2, v: 1'b1, e: 1'b1, r: 4'd2, d: 16'h1000, l: 4'd0};
        tbl[3] = '{n: 3, v: 1'b1, e: 1'b0, r: 4'd2, d: 16'h1000, l: 4'd1};
        tbl[4] = '{n: 5, v: 1'b1, e: 1'b0, r: 4'd2, d: 16'h1000, l: 4'd3};
        tbl[5] = '{n: 8, v: 1'b1, e: 1'b0, r: 4'd2, d: 16'h1000, l: 4'd6};

        // Reset with a nonzero write pointer present
        rd_rst = 1'b1;
        g_wptr = 4'b0110;
        repeat (2) tick();
        rd_rst = 1'b0;
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_valid", 32'(s_if.m_valid), 32'd0);
        check("rst_b_rptr", 32'(b_rptr), 32'd0);
        check("rst_g_rptr", 32'(g_rptr), 32'd0);
        check("rst_m_data", 32'(s_if.m_data), 32'd0);
        check("rst_level", 32'(rd_level), 32'd0);
        tick();
        check("rst_sync_lag", 32'(fifo_empty), 32'd1);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        do_reset();
        mon_en = 1'b1;

        // Vector table: n words written, consumer stalled, steady state
        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int k = 0; k < tbl[i].n; k++) write_word(16'(16'h1000 + k));
            repeat (8) tick();
`ifdef FIFO_RD_LEVEL_EN
            exp_l = tbl[i].l;
`else
            exp_l = 4'd0;
`endif
            check("tbl_valid", 32'(s_if.m_valid), 32'(tbl[i].v));
            check("tbl_empty", 32'(fifo_empty), 32'(tbl[i].e));
            check("tbl_b_rptr", 32'(b_rptr), 32'(tbl[i].r));
            check("tbl_m_data", 32'(s_if.m_data), 32'(tbl[i].d));
            check("tbl_level", 32'(rd_level), 32'(exp_l));
        end

        // Single word latency
        do_reset();
        write_word(16'hA5A5);
        check("sw_empty0", 32'(fifo_empty), 32'd1);
        tick();
        check("sw_empty1", 32'(fifo_empty), 32'd1);
        check("sw_rd_en1", 32'(rd_en), 32'd0);
        tick();
        check("sw_empty2", 32'(fifo_empty), 32'd0);
        check("sw_rd_en2", 32'(rd_en), 32'd1);
        check("sw_b_rptr2", 32'(b_rptr), 32'd0);
        tick();
        check("sw_rd_en3", 32'(rd_en), 32'd0);
        check("sw_g_rptr3", 32'(g_rptr), 32'd1);
        check("sw_valid3", 32'(s_if.m_valid), 32'd0);
        tick();
        check("sw_valid4", 32'(s_if.m_valid), 32'd1);
        check("sw_data4", 32'(s_if.m_data), 32'hA5A5);
        s_if.m_ready = 1'b1;
        tick();
        check("sw_drained", 32'(s_if.m_valid), 32'd0);

        // Backpressure: two reads then stall, then full-rate drain
        do_reset();
        for (int k = 0; k < 8; k++) write_word(16'(16'h2000 + k));
        cnt = 0;
        repeat (10) begin
            if (rd_en) cnt++;
            tick();
        end
        check("bp_pulses", 32'(cnt), 32'd2);
        check("bp_head", 32'(s_if.m_data), 32'h2000);
        s_if.m_ready = 1'b1;
        cnt = 0;
        repeat (8) begin
            if (s_if.m_valid) cnt++;
            tick();
        end
        check("bp_rate", 32'(cnt), 32'd8);
        check("bp_empty", 32'(fifo_empty), 32'd1);
        check("bp_valid", 32'(s_if.m_valid), 32'd0);

        // Level tracking while stalled
        do_reset();
        for (int k = 0; k < 5; k++) write_word(16'(16'h4000 + k));
        seen = 1'b0;
        repeat (8) begin
`ifdef FIFO_RD_LEVEL_EN
            if (rd_level == 4'd5) seen = 1'b1;
`else
            check("lvl_off", 32'(rd_level), 32'd0);
`endif
            tick();
        end
`ifdef FIFO_RD_LEVEL_EN
        check("lvl_seen5", 32'(seen), 32'd1);
        check("lvl_after2", 32'(rd_level), 32'd3);
`endif

        // Reset mid-burst with a word buffered and a read in flight
        do_reset();
        s_if.m_ready = 1'b1;
        for (int k = 0; k < 6; k++) write_word(16'(16'h3000 + k));
        cnt = 0;
        while (!s_if.m_valid && cnt < 10) begin
            tick();
            cnt++;
        end
        check("mid_started", 32'(s_if.m_valid), 32'd1);
        rd_rst = 1'b1;
        g_wptr = 4'd0;
        wptr = 0;
        tick();
        check("mid_valid", 32'(s_if.m_valid), 32'd0);
        check("mid_b_rptr", 32'(b_rptr), 32'd0);
        rd_rst = 1'b0;
        repeat (3) begin
            tick();
            check("mid_no_stale", 32'(s_if.m_valid), 32'd0);
        end

        // Random traffic with wrap-around
        do_reset();
        for (int c = 0; c < 600; c++) begin
            s_if.m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0 && (wptr - rd_cnt) < 8) write_word(16'($urandom));
            tick();
        end
        s_if.m_ready = 1'b1;
        cnt = 0;
        while ((exp_q.size() != 0 || s_if.m_valid) && cnt < 40) begin
            tick();
            cnt++;
        end
        check("rnd_drained", 32'(exp_q.size()), 32'd0);
        check("rnd_wrapped", 32'(rd_cnt >= 20), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
